// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation select codes and FSM states.
// Op codes mirror the MD_* controller encodings used by the decode stage.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  // Multi-cycle ops that occupy the unit.
  function automatic logic md_is_iter(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Multiply and divide share one
// 2*WIDTH shift register and one WIDTH+1 adder; operands are held as magnitudes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes and result signs captured at the start edge.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    sign_a = md_is_signed(MDOp) & A[WIDTH-1];
    sign_b = md_is_signed(MDOp) & B[WIDTH-1];
    mag_a  = sign_a ? -A : A;
    mag_b  = sign_b ? -B : B;
  end

  // Shared adder: add for multiply, subtract (x + ~y + 1) for divide.
  logic [WIDTH:0] add_x, add_y, sum;

  always_comb begin
    add_x = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y = is_div_q ? ~{1'b0, b_q} : {1'b0, b_q};
    sum   = add_x + add_y + {{WIDTH{1'b0}}, is_div_q};
  end

  logic [2*WIDTH-1:0] step;

  always_comb begin
    if (is_div_q) begin
      // Restoring step: keep the difference only when it did not go negative.
      step = sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                        : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    quot_fix = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_is_iter(MDOp)) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            b_d      = mag_b;
            cnt_d    = '0;
            is_div_d = md_is_div(MDOp);
            // A zero divisor yields an all-ones quotient that must not be negated;
            // the remainder then restores to A through the dividend sign.
            neg_q_d  = (sign_a ^ sign_b) & ~(md_is_div(MDOp) && (B == '0));
            neg_r_d  = sign_a;
            state_d  = MD_CALC;
          end else if (MDOp == MD_MTHI) begin
            hi_d = A;
          end else if (MDOp == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      MD_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8, compared against an
// arithmetic reference model of the HI/LO results.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start32), .MDOp(op32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .HI(hi32), .LO(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .MDOp(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
  );

  // Reference: returns {HI, LO}, each masked to w bits in a 32-bit field.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a_in,
                                        input logic [31:0] b_in, input int w);
    logic [63:0] mask, a, b, pu, hi, lo;
    longint sa, sb, q, r, most_neg;
    mask = (64'd1 << w) - 64'd1;
    a = {32'd0, a_in} & mask;
    b = {32'd0, b_in} & mask;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    most_neg = -(longint'(1) << (w - 1));
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        pu = 64'(sa * sb);
        hi = (pu >> w) & mask;
        lo = pu & mask;
      end
      OP_MULTU: begin
        pu = a * b;
        hi = (pu >> w) & mask;
        lo = pu & mask;
      end
      OP_DIV: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else if (sa == most_neg && sb == -1) begin
          lo = a;
          hi = '0;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = 64'(q) & mask;
          hi = 64'(r) & mask;
        end
      end
      OP_DIVU: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  // Issues one op at the current (negedge) time and returns at the negedge where done=1.
  // Operands are scrambled right after the start edge to prove they were captured.
  task automatic do_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo,
                       output int busy_n);
    int guard;
    if (w8) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0; op8 = OP_NOP; op32 = OP_NOP;
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    busy_n = 0;
    guard  = 0;
    while (!(w8 ? done8 : done32) && guard < 200) begin
      if (w8 ? busy8 : busy32) busy_n++;
      guard++;
      @(negedge clk);
    end
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL op_timeout: op=%0d no done after %0d cycles", op, guard);
    end
    hi = w8 ? {24'd0, hi8} : hi32;
    lo = w8 ? {24'd0, lo8} : lo32;
  endtask

  task automatic test_reset;
    n_checks += 4;
    if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy32); end
    if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done32); end
    if (hi32 !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi32); end
    if (lo32 !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo32); end
    n_checks += 2;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    if ({hi8, lo8} !== 16'd0) begin
      n_fail++; $display("FAIL reset_hilo8: got %h want 0", {hi8, lo8});
    end
  endtask

  // Runs one op and checks HI, LO, busy length and the done-cycle busy level.
  task automatic run_check(input string name, input bit w8, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    logic [63:0] exp;
    int bn, want_bn;
    want_bn = w8 ? 9 : 33;
    exp = model(op, a, b, w8 ? 8 : 32);
    do_op(w8, op, a, b, hi, lo, bn);
    n_checks += 4;
    if (hi !== exp[63:32]) begin
      n_fail++; $display("FAIL %s_hi: a=%h b=%h got %h want %h", name, a, b, hi, exp[63:32]);
    end
    if (lo !== exp[31:0]) begin
      n_fail++; $display("FAIL %s_lo: a=%h b=%h got %h want %h", name, a, b, lo, exp[31:0]);
    end
    if (bn !== want_bn) begin
      n_fail++; $display("FAIL %s_busy_len: got %0d want %0d", name, bn, want_bn);
    end
    if ((w8 ? busy8 : busy32) !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_at_done: got 1 want 0", name);
    end
  endtask

  task automatic test_multu_max;
    run_check("multu_max", 1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks += 3;
    if (hi32 !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu_max_hi_const: got %h want FFFFFFFE", hi32);
    end
    if (lo32 !== 32'h0000_0001) begin
      n_fail++; $display("FAIL multu_max_lo_const: got %h want 00000001", lo32);
    end
    @(negedge clk);
    if (done32 !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got 1 want 0"); end
  endtask

  task automatic test_signed;
    run_check("mult_neg", 1'b0, OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    run_check("div_neg", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    n_checks += 2;
    if (lo32 !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_neg_lo_const: got %h want FFFFFFFD", lo32);
    end
    if (hi32 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_neg_hi_const: got %h want FFFFFFFF", hi32);
    end
  endtask

  task automatic test_div_corners;
    run_check("divu_zero", 1'b0, OP_DIVU, 32'h0000_1234, 32'h0);
    run_check("div_zero_neg", 1'b0, OP_DIV, 32'hFFFF_FF00, 32'h0);
    run_check("div_ovf", 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_checks += 2;
    if (lo32 !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_ovf_lo_const: got %h want 80000000", lo32);
    end
    if (hi32 !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi_const: got %h want 0", hi32); end
    run_check("mult_minneg", 1'b0, OP_MULT, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_mt;
    logic [31:0] hi_before;
    hi_before = hi32;
    start32 = 1'b1; op32 = OP_MTLO; a32 = 32'hCAFE_F00D;
    @(negedge clk);
    start32 = 1'b0; op32 = OP_NOP;
    n_checks += 4;
    if (lo32 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mtlo_lo: got %h want CAFEF00D", lo32); end
    if (hi32 !== hi_before) begin n_fail++; $display("FAIL mtlo_hi: got %h want %h", hi32, hi_before); end
    if (busy32 !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got 1 want 0"); end
    if (done32 !== 1'b0) begin n_fail++; $display("FAIL mtlo_done: got 1 want 0"); end
    start32 = 1'b1; op32 = OP_MTHI; a32 = 32'h0BAD_C0DE;
    @(negedge clk);
    start32 = 1'b0; op32 = OP_NOP;
    n_checks += 2;
    if (hi32 !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL mthi_hi: got %h want 0BADC0DE", hi32); end
    if (lo32 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mthi_lo: got %h want CAFEF00D", lo32); end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] exp;
    logic [31:0] hi_before;
    int guard;
    hi_before = hi32;
    exp = model(OP_DIVU, 32'h1234_5678, 32'h0000_1234, 32);
    start32 = 1'b1; op32 = OP_DIVU; a32 = 32'h1234_5678; b32 = 32'h0000_1234;
    @(negedge clk);
    start32 = 1'b0; op32 = OP_NOP;
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = OP_MTHI; a32 = 32'hDEAD_BEEF; b32 = 32'h1;
    @(negedge clk);
    start32 = 1'b0; op32 = OP_NOP;
    n_checks += 2;
    if (hi32 !== hi_before) begin
      n_fail++; $display("FAIL busy_hi_stable: got %h want %h", hi32, hi_before);
    end
    if (busy32 !== 1'b1) begin n_fail++; $display("FAIL busy_mid_op: got 0 want 1"); end
    guard = 0;
    while (!done32 && guard < 100) begin guard++; @(negedge clk); end
    n_checks += 2;
    if (hi32 !== exp[63:32]) begin
      n_fail++; $display("FAIL busy_ignore_hi: got %h want %h", hi32, exp[63:32]);
    end
    if (lo32 !== exp[31:0]) begin
      n_fail++; $display("FAIL busy_ignore_lo: got %h want %h", lo32, exp[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    start32 = 1'b1; op32 = OP_MULT; a32 = 32'h0001_2345; b32 = 32'hFFFF_0F0F;
    @(negedge clk);
    start32 = 1'b0; op32 = OP_NOP;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 4;
    if (busy32 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got 1 want 0"); end
    if (done32 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got 1 want 0"); end
    if (hi32 !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", hi32); end
    if (lo32 !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", lo32); end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done |= done32;
    end
    n_checks += 2;
    if (saw_done) begin n_fail++; $display("FAIL rst_mid_late_done: got done pulse want none"); end
    if ({hi32, lo32} !== 64'd0) begin
      n_fail++; $display("FAIL rst_mid_hilo_hold: got %h want 0", {hi32, lo32});
    end
  endtask

  task automatic test_width8;
    run_check("w8_multu", 1'b1, OP_MULTU, 32'hFF, 32'hFF);
    n_checks += 1;
    if ({hi8, lo8} !== 16'hFE01) begin
      n_fail++; $display("FAIL w8_multu_const: got %h want FE01", {hi8, lo8});
    end
    run_check("w8_divu", 1'b1, OP_DIVU, 32'hC8, 32'h07);
    n_checks += 1;
    if ({hi8, lo8} !== 16'h041C) begin
      n_fail++; $display("FAIL w8_divu_const: got %h want 041C", {hi8, lo8});
    end
    run_check("w8_div_ovf", 1'b1, OP_DIV, 32'h80, 32'hFF);
    run_check("w8_div_zero", 1'b1, OP_DIV, 32'h85, 32'h00);
  endtask

  task automatic pick(output logic [31:0] v);
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'd1;
      4: v = 32'h0000_0080;
      default: v = $urandom;
    endcase
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [2:0] op;
    bit w8;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      w8 = 1'($urandom_range(0, 1));
      pick(a);
      pick(b);
      run_check("random", w8, op, a, b);
    end
  endtask

  // Each op starts in the done cycle of the previous one.
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      run_check("b2b", 1'b0, 3'($urandom_range(1, 4)), $urandom, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start32 = 1'b0; start8 = 1'b0; op32 = OP_NOP; op8 = OP_NOP;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corners();
    test_mt();
    test_busy_ignore();
    @(negedge clk);
    test_reset_mid();
    test_width8();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the tiny-CPU datapath. It sits beside the combinational ALU in EX.
- Handles mult/multu/div/divu, which take several cycles, and mthi/mtlo, which take one. mfhi/mflo read the HI/LO outputs directly.
- Parametrised in data width. Exposes busy so the hazard unit can stall the pipeline.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  op request, sampled only when busy=0
- MDOp  input  3  operation select, encodings `MD_*
- A  input  WIDTH  rs operand: dividend / multiplicand / mthi-mtlo source
- B  input  WIDTH  rt operand: divisor / multiplier
- busy  output  1  unit occupied; pipeline stalls on MD ops and mfhi/mflo
- done  output  1  one-cycle pulse when HI/LO updated by a multi-cycle op
- HI  output  WIDTH  HI register (remainder / product upper half)
- LO  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (rst=1 at a clock edge): HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
  - rst has priority over everything.
  - rst mid-operation aborts the op; HI/LO read 0.
- States: IDLE, CALC, FIX.
  - IDLE, start=1, MDOp in {MULT, MULTU, DIV, DIVU}: latch magnitudes of A and B (signed ops take two's-complement absolute value), latch result signs, clear counter, go to CALC.
  - IDLE, start=1, MDOp=MTHI: HI<=A in one edge; no busy, no done.
  - IDLE, start=1, MDOp=MTLO: LO<=A in one edge; no busy, no done.
  - IDLE, start=1, MDOp=NOP or undefined: no effect.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After WIDTH steps go to FIX.
  - FIX: apply sign correction, write HI/LO, done=1 for this cycle only, return to IDLE.
- busy=1 whenever state != IDLE.
- Latency: busy is high for WIDTH+1 cycles after the start edge. HI/LO hold the new values in the cycle done=1, and busy=0 in that same cycle. For WIDTH=32 that is 33 busy cycles.
- start while busy=1 is ignored, including MTHI/MTLO. Operands are captured at the start edge, so A/B changes afterwards have no effect.
- Multiply: full 2*WIDTH product, {HI,LO}.
  - MULT is signed; the product is negated in FIX when the operand signs differ.
  - MULTU is unsigned.
- Divide: LO=quotient, HI=remainder.
  - Quotient truncates toward zero; quotient sign = sA^sB; remainder sign = sA.
  - Divide by zero, DIV and DIVU: LO = all ones, HI = A unchanged. Still takes the full latency; no exception.
  - Signed overflow (A = most-negative, B = -1): LO = most-negative, HI = 0.
- HI/LO are stable between ops. They change only on a reset edge, a FIX edge, or an MTHI/MTLO edge.

Decomposition:
- Add to include/ctrl_encode_def.v as 3-bit `define constants:
  - MD_NOP=000, MD_MULT=001, MD_MULTU=010, MD_DIV=011, MD_DIVU=100, MD_MTHI=101, MD_MTLO=110
  - State encodings MD_IDLE / MD_CALC / MD_FIX
- No sub-module required. Multiply and divide share one 2*WIDTH shift register and one WIDTH+1 adder/subtractor inside the module.

Test Plan:
- MULTU, WIDTH=32, A=FFFFFFFF, B=FFFFFFFF -> busy high 33 cycles, then done pulse with HI=FFFFFFFE, LO=00000001.
- MULT A=FFFFFFFD (-3), B=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1. Then DIV A=FFFFFFF9 (-7), B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU A=00001234, B=0 -> LO=FFFFFFFF, HI=00001234. DIV A=80000000, B=FFFFFFFF -> LO=80000000, HI=00000000.
- During a busy DIVU, pulse start with MTHI and change A/B -> ignored; result matches the original operands. MTLO A=CAFEF00D when idle -> LO=CAFEF00D next cycle, busy and done stay 0.
- Assert rst at cycle 10 of a MULT -> next cycle busy=0, done=0, HI=LO=0. No done pulse afterwards.
- WIDTH=8: MULTU FF*FF -> HI=FE, LO=01 after 9 busy cycles. DIVU C8/07 -> LO=1C, HI=04.
